// File: rtl/dct_sched_pkg.sv
// Shared types, constants and the raster tile/element address mapping
// for the dct2d frame scheduler.
package dct_sched_pkg;

    localparam int unsigned TILE      = 8;
    localparam int unsigned WIN_ELEMS = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        CAPTURE,
        STORE,
        DONE
    } state_t;

    // Element e = r*8+c of tile t maps to (ty*8+r)*img_dim + tx*8+c.
    function automatic int unsigned tile_addr(input int unsigned img_dim,
                                              input int unsigned tile,
                                              input int unsigned elem);
        int unsigned tiles_per_row;
        int unsigned ty;
        int unsigned tx;
        tiles_per_row = img_dim / TILE;
        ty = tile / tiles_per_row;
        tx = tile % tiles_per_row;
        return (ty * TILE + elem / TILE) * img_dim + tx * TILE + elem % TILE;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Tile and element counters plus the combinational pixel/result address
// derived from them.
module tile_addr_gen
    import dct_sched_pkg::*;
#(
    parameter int unsigned IMG_DIM = 128,
    parameter int unsigned ADDR_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tile_clr,
    input  logic              tile_inc,
    input  logic              elem_inc,
    input  logic              elem_clr,
    output logic [15:0]       tile_idx,
    output logic [5:0]        elem,
    output logic              last_tile,
    output logic [ADDR_W-1:0] addr
);

    localparam int unsigned NUM_TILES = (IMG_DIM / TILE) * (IMG_DIM / TILE);

    always_ff @(posedge clk) begin
        if (rst || tile_clr) begin
            tile_idx <= '0;
            elem     <= '0;
        end else begin
            // The tile counter saturates on the last tile of the frame.
            if (tile_inc && !last_tile)
                tile_idx <= tile_idx + 16'd1;
            if (elem_clr)
                elem <= '0;
            else if (elem_inc)
                elem <= elem + 6'd1;
        end
    end

    assign last_tile = (tile_idx == 16'(NUM_TILES - 1));
    assign addr      = ADDR_W'(tile_addr(IMG_DIM, {16'b0, tile_idx}, {26'b0, elem}));

endmodule

// File: rtl/dct_tile_scheduler.sv
// Frame sequencer for the dct2d core: loads each 8x8 window, waits out the
// core latency, snapshots its output and streams the coefficients out.
module dct_tile_scheduler
    import dct_sched_pkg::*;
#(
    parameter int unsigned N       = 16,
    parameter int unsigned IMG_DIM = 128,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DCT_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            tile_idx,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [N-1:0]           rd_data,
    output logic [N*WIN_ELEMS-1:0] win_data,
    input  logic [N*WIN_ELEMS-1:0] dct_data,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [N-1:0]           wr_data,
    input  logic                   wr_ready
);

    localparam logic [7:0] LAT_LAST = 8'((DCT_LAT == 0) ? 0 : DCT_LAT - 1);

    state_t                   state;
    logic [5:0]               elem;
    logic                     last_tile;
    logic [ADDR_W-1:0]        addr;
    logic                     cap_en;
    logic [5:0]               cap_idx;
    logic [7:0]               wait_cnt;
    logic [N*WIN_ELEMS-1:0]   obuf;
    logic                     wr_accept;
    logic                     tile_clr;
    logic                     tile_inc;
    logic                     elem_inc;
    logic                     elem_clr;

    tile_addr_gen #(
        .IMG_DIM (IMG_DIM),
        .ADDR_W  (ADDR_W)
    ) u_addr (
        .clk       (clk),
        .rst       (rst),
        .tile_clr  (tile_clr),
        .tile_inc  (tile_inc),
        .elem_inc  (elem_inc),
        .elem_clr  (elem_clr),
        .tile_idx  (tile_idx),
        .elem      (elem),
        .last_tile (last_tile),
        .addr      (addr)
    );

    // In LOAD, rd_en low marks the 65th cycle where the last read lands.
    always_comb begin
        wr_accept = (state == STORE) && wr_en && wr_ready;
        tile_clr  = (state == IDLE) && start;
        elem_inc  = ((state == LOAD) && rd_en && (elem != 6'd63))
                  || (wr_accept && (elem != 6'd63));
        elem_clr  = ((state == LOAD) && !rd_en)
                  || (wr_accept && (elem == 6'd63));
        tile_inc  = wr_accept && (elem == 6'd63);
        wr_data   = obuf[32'(elem) * N +: N];
    end

    assign rd_addr = addr;
    assign wr_addr = addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            wr_en    <= 1'b0;
            cap_en   <= 1'b0;
            cap_idx  <= '0;
            wait_cnt <= '0;
            win_data <= '0;
            obuf     <= '0;
        end else begin
            done    <= 1'b0;
            cap_en  <= rd_en;
            cap_idx <= elem;
            if (cap_en)
                win_data[32'(cap_idx) * N +: N] <= rd_data;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        rd_en <= 1'b1;
                    end
                end
                LOAD: begin
                    busy <= 1'b1;
                    if (rd_en && (elem == 6'd63))
                        rd_en <= 1'b0;
                    if (!rd_en) begin
                        state    <= (DCT_LAT == 0) ? CAPTURE : WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (wait_cnt == LAT_LAST)
                        state <= CAPTURE;
                    else
                        wait_cnt <= wait_cnt + 8'd1;
                end
                CAPTURE: begin
                    obuf  <= dct_data;
                    wr_en <= 1'b1;
                    state <= STORE;
                end
                STORE: begin
                    if (wr_accept && (elem == 6'd63)) begin
                        wr_en <= 1'b0;
                        if (last_tile) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= LOAD;
                            rd_en <= 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_tile_scheduler.sv
// Directed bench: three scheduler instances (8x8/lat 3, 128x128/lat 4,
// 16x16/lat 0) each with a pixel memory model and an identity dct2d stub.
module tb_dct_tile_scheduler;

    localparam int unsigned N  = 16;
    localparam int unsigned AW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic            rst_a, start_a, busy_a, done_a, rd_en_a, wr_en_a, rdy_a;
    logic [15:0]     tile_a;
    logic [AW-1:0]   rd_addr_a, wr_addr_a;
    logic [N-1:0]    rd_data_a, wr_data_a;
    logic [N*64-1:0] win_a, dct_a;

    logic            rst_b, start_b, busy_b, done_b, rd_en_b, wr_en_b, rdy_b;
    logic [15:0]     tile_b;
    logic [AW-1:0]   rd_addr_b, wr_addr_b;
    logic [N-1:0]    rd_data_b, wr_data_b;
    logic [N*64-1:0] win_b, dct_b;

    logic            rst_c, start_c, busy_c, done_c, rd_en_c, wr_en_c, rdy_c;
    logic [15:0]     tile_c;
    logic [AW-1:0]   rd_addr_c, wr_addr_c;
    logic [N-1:0]    rd_data_c, wr_data_c;
    logic [N*64-1:0] win_c, dct_c;

    dct_tile_scheduler #(.N(N), .IMG_DIM(8), .ADDR_W(AW), .DCT_LAT(3)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .tile_idx(tile_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .win_data(win_a), .dct_data(dct_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .wr_ready(rdy_a));

    dct_tile_scheduler #(.N(N), .IMG_DIM(128), .ADDR_W(AW), .DCT_LAT(4)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .tile_idx(tile_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .win_data(win_b), .dct_data(dct_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .wr_ready(rdy_b));

    dct_tile_scheduler #(.N(N), .IMG_DIM(16), .ADDR_W(AW), .DCT_LAT(0)) dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .busy(busy_c), .done(done_c),
        .tile_idx(tile_c), .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
        .win_data(win_c), .dct_data(dct_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
        .wr_data(wr_data_c), .wr_ready(rdy_c));

    // Pixel memories: a and b hold mem[a]=a, c holds mem[a]=a^16'hA500.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= {2'b0, rd_addr_a};
        if (rd_en_b) rd_data_b <= {2'b0, rd_addr_b};
        if (rd_en_c) rd_data_c <= {2'b0, rd_addr_c} ^ 16'hA500;
    end

    assign dct_a = win_a;
    assign dct_b = win_b;
    assign dct_c = win_c;

    function automatic int unsigned exp_addr(input int unsigned dim, input int unsigned t,
                                             input int unsigned e);
        int unsigned tpr;
        tpr = dim / 8;
        return ((t / tpr) * 8 + e / 8) * dim + (t % tpr) * 8 + e % 8;
    endfunction

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, done_a, rd_en_a, wr_en_a} !== 4'b0) begin
            errors++; $display("FAIL reset_a_ctrl got %b exp 0000", {busy_a, done_a, rd_en_a, wr_en_a});
        end
        checks++;
        if (tile_a !== 16'd0) begin errors++; $display("FAIL reset_a_tile got %0d exp 0", tile_a); end
        checks++;
        if (rd_addr_a !== '0 || wr_addr_a !== '0) begin
            errors++; $display("FAIL reset_a_addr got %0d/%0d exp 0/0", rd_addr_a, wr_addr_a);
        end
        checks++;
        if (wr_data_a !== '0) begin errors++; $display("FAIL reset_a_wdata got %0d exp 0", wr_data_a); end
        checks++;
        if (win_a !== '0) begin errors++; $display("FAIL reset_a_win got nonzero exp 0"); end
        checks++;
        if ({busy_b, done_b, rd_en_b, wr_en_b, busy_c, done_c, rd_en_c, wr_en_c} !== 8'b0) begin
            errors++; $display("FAIL reset_bc_ctrl got %b exp 0", {busy_b, done_b, rd_en_b, wr_en_b, busy_c, done_c, rd_en_c, wr_en_c});
        end
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame;
        int rd_cnt = 0, wr_cnt = 0, busy_cnt = 0, done_cnt = 0, done_at = -1, first_wr = -1;
        rdy_a = 1'b1;
        @(negedge clk); start_a = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k == 0) start_a = 1'b0;
            if (rd_en_a) begin
                checks++;
                if (rd_addr_a !== AW'(rd_cnt) || k != rd_cnt) begin
                    errors++; $display("FAIL single_rd_addr got %0d at k=%0d exp %0d", rd_addr_a, k, rd_cnt);
                end
                rd_cnt++;
            end
            if (wr_en_a && rdy_a) begin
                if (first_wr < 0) first_wr = k;
                checks++;
                if (wr_addr_a !== AW'(wr_cnt) || wr_data_a !== N'(wr_cnt)) begin
                    errors++; $display("FAIL single_write got %0d/%0d exp %0d", wr_addr_a, wr_data_a, wr_cnt);
                end
                wr_cnt++;
            end
            if (busy_a) busy_cnt++;
            if (done_a) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
                checks++;
                if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy_at_done got 1 exp 0"); end
            end
        end
        checks++;
        if (done_at != 133) begin errors++; $display("FAIL single_done_cycle got %0d exp 133", done_at); end
        checks++;
        if (busy_cnt != 132) begin errors++; $display("FAIL single_busy_len got %0d exp 132", busy_cnt); end
        checks++;
        if (rd_cnt != 64 || wr_cnt != 64) begin
            errors++; $display("FAIL single_counts got rd %0d wr %0d exp 64 64", rd_cnt, wr_cnt);
        end
        checks++;
        if (first_wr != 69) begin errors++; $display("FAIL single_first_write got %0d exp 69", first_wr); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL single_done_pulses got %0d exp 1", done_cnt); end
    endtask

    task automatic test_start_ignored;
        int done_cnt = 0, done_at = -1, wr_cnt = 0;
        rdy_a = 1'b1;
        @(negedge clk); start_a = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            start_a = (k == 10) || (k == 66);
            if (wr_en_a && rdy_a) wr_cnt++;
            if (done_a) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        checks++;
        if (done_cnt != 1 || done_at != 133) begin
            errors++; $display("FAIL ignore_start_done got %0d pulses at %0d exp 1 at 133", done_cnt, done_at);
        end
        checks++;
        if (wr_cnt != 64) begin errors++; $display("FAIL ignore_start_writes got %0d exp 64", wr_cnt); end
        checks++;
        if (busy_a !== 1'b0 || rd_en_a !== 1'b0) begin
            errors++; $display("FAIL ignore_start_idle got busy %b rd_en %b exp 0 0", busy_a, rd_en_a);
        end
    endtask

    task automatic run_frame_c(input string name, input logic check_period);
        int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_at = -1, first_wr = -1;
        int tstart[4];
        rdy_c = 1'b1;
        @(negedge clk); start_c = 1'b1;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            if (k == 0) start_c = 1'b0;
            if (rd_en_c) begin
                if (rd_cnt % 64 == 0) tstart[rd_cnt / 64] = k;
                checks++;
                if (rd_addr_c !== AW'(exp_addr(16, rd_cnt / 64, rd_cnt % 64))) begin
                    errors++; $display("FAIL %s_rd_addr got %0d exp %0d", name, rd_addr_c, exp_addr(16, rd_cnt / 64, rd_cnt % 64));
                end
                rd_cnt++;
            end
            if (wr_en_c && rdy_c) begin
                if (first_wr < 0) first_wr = k;
                checks++;
                if (wr_addr_c !== AW'(exp_addr(16, wr_cnt / 64, wr_cnt % 64))
                    || wr_data_c !== (N'(exp_addr(16, wr_cnt / 64, wr_cnt % 64)) ^ 16'hA500)) begin
                    errors++; $display("FAIL %s_write got %0d/%h exp addr %0d", name, wr_addr_c, wr_data_c, exp_addr(16, wr_cnt / 64, wr_cnt % 64));
                end
                wr_cnt++;
            end
            if (done_c) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        checks++;
        if (done_at != 520 || done_cnt != 1) begin
            errors++; $display("FAIL %s_done got %0d pulses at %0d exp 1 at 520", name, done_cnt, done_at);
        end
        checks++;
        if (wr_cnt != 256 || rd_cnt != 256) begin
            errors++; $display("FAIL %s_counts got rd %0d wr %0d exp 256 256", name, rd_cnt, wr_cnt);
        end
        if (check_period) begin
            checks++;
            if (first_wr != 66) begin errors++; $display("FAIL %s_capture_follows_load got first write %0d exp 66", name, first_wr); end
            checks++;
            if (rd_cnt == 256 && (tstart[0] != 0 || tstart[1] != 130 || tstart[2] != 260 || tstart[3] != 390)) begin
                errors++; $display("FAIL %s_tile_period got %0d %0d %0d %0d exp 0 130 260 390", name, tstart[0], tstart[1], tstart[2], tstart[3]);
            end
        end
    endtask

    task automatic test_zero_latency;
        run_frame_c("zero_lat", 1'b1);
    endtask

    task automatic test_stall;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int wr_cnt = 0, done_cnt = 0, done_at = -1;
        logic held = 1'b0;
        logic [AW-1:0] h_addr = '0;
        logic [N-1:0]  h_data = '0;
        @(negedge clk); start_c = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (k == 0) start_c = 1'b0;
            rdy_c = pat[k % 4];
            if (held) begin
                checks++;
                if (wr_en_c !== 1'b1 || wr_addr_c !== h_addr || wr_data_c !== h_data) begin
                    errors++; $display("FAIL stall_hold got %0d/%h exp %0d/%h", wr_addr_c, wr_data_c, h_addr, h_data);
                end
            end
            held = wr_en_c && !rdy_c;
            h_addr = wr_addr_c;
            h_data = wr_data_c;
            if (wr_en_c && rdy_c) begin
                checks++;
                if (wr_addr_c !== AW'(exp_addr(16, wr_cnt / 64, wr_cnt % 64))
                    || wr_data_c !== (N'(exp_addr(16, wr_cnt / 64, wr_cnt % 64)) ^ 16'hA500)
                    || tile_c !== 16'(wr_cnt / 64)) begin
                    errors++; $display("FAIL stall_write got %0d/%h tile %0d exp write %0d", wr_addr_c, wr_data_c, tile_c, wr_cnt);
                end
                wr_cnt++;
            end
            if (done_c) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (done_at >= 0 && k > done_at + 3) break;
        end
        rdy_c = 1'b1;
        checks++;
        if (wr_cnt != 256) begin errors++; $display("FAIL stall_write_count got %0d exp 256", wr_cnt); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL stall_done got %0d exp 1", done_cnt); end
    endtask

    task automatic test_reset_mid_store;
        logic found = 1'b0;
        int stray = 0;
        rdy_c = 1'b1;
        @(negedge clk); start_c = 1'b1;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk);
            if (k == 0) start_c = 1'b0;
            if (tile_c == 16'd2 && wr_en_c && wr_addr_c == AW'(exp_addr(16, 2, 10))) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_store_reach got 0 exp 1"); end
        rst_c = 1'b1;
        @(negedge clk);
        rst_c = 1'b0;
        checks++;
        if ({busy_c, done_c, rd_en_c, wr_en_c} !== 4'b0 || tile_c !== 16'd0) begin
            errors++; $display("FAIL rst_store_ctrl got %b tile %0d exp 0000 tile 0", {busy_c, done_c, rd_en_c, wr_en_c}, tile_c);
        end
        checks++;
        if (rd_addr_c !== '0 || wr_addr_c !== '0 || wr_data_c !== '0 || win_c !== '0) begin
            errors++; $display("FAIL rst_store_data got addr %0d/%0d data %h exp 0", rd_addr_c, wr_addr_c, wr_data_c);
        end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done_c || busy_c || rd_en_c || wr_en_c) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL rst_store_quiet got %0d active cycles exp 0", stray); end
        run_frame_c("rst_restart", 1'b0);
    endtask

    task automatic test_big_frame;
        int first17 = -1, last17 = -1, done_at = -1, done_cnt = 0, wr17 = -1;
        logic [N-1:0] wd17 = '0;
        logic [15:0]  tile_at_done = '0;
        rdy_b = 1'b1;
        @(negedge clk); start_b = 1'b1;
        for (int k = 0; k < 35000; k++) begin
            @(negedge clk);
            if (k == 0) start_b = 1'b0;
            if (rd_en_b && tile_b == 16'd17) begin
                if (first17 < 0) first17 = int'(rd_addr_b);
                last17 = int'(rd_addr_b);
            end
            if (wr_en_b && tile_b == 16'd17 && wr17 < 0) begin
                wr17 = int'(wr_addr_b);
                wd17 = wr_data_b;
            end
            if (done_b) begin
                done_cnt++;
                if (done_at < 0) begin done_at = k; tile_at_done = tile_b; end
            end
            if (done_at >= 0 && k > done_at + 3) break;
        end
        checks++;
        if (first17 != 1032) begin errors++; $display("FAIL big_first_rd got %0d exp 1032", first17); end
        checks++;
        if (last17 != 1935) begin errors++; $display("FAIL big_last_rd got %0d exp 1935", last17); end
        checks++;
        if (wr17 != 1032 || wd17 !== 16'd1032) begin
            errors++; $display("FAIL big_first_wr got %0d/%0d exp 1032/1032", wr17, wd17);
        end
        checks++;
        if (done_at != 34304 || done_cnt != 1) begin
            errors++; $display("FAIL big_done got %0d pulses at %0d exp 1 at 34304", done_cnt, done_at);
        end
        checks++;
        if (tile_at_done !== 16'd255) begin errors++; $display("FAIL big_last_tile got %0d exp 255", tile_at_done); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_start_ignored();
        test_zero_latency();
        test_stall();
        test_reset_mid_store();
        test_big_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
